// File: rtl/clarke_pkg.sv
// Shared constants and types for the Clarke transform and its scheduler.
// Used by the RTL and by the bench reference model.
package clarke_pkg;

    localparam int CLARKE_D_WIDTH = 18;
    localparam int CLARKE_Q_BITS  = 15;

    // 1/sqrt(3) in Q15
    localparam int ONE_DIV_SQRT3  = 18918;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } clarke_sched_state_t;

endpackage

// File: rtl/clarke_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins.
// Shared by the datapath schedulers (Clarke, Park, SVM).
module rr_arbiter
    import clarke_pkg::*;
#(
    parameter int N    = 4,
    parameter int CH_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [CH_W-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [CH_W-1:0] gnt_idx,
    output logic            any
);

    int              w_sum;
    logic [CH_W-1:0] w_k;

    // Scan from ptr with wrap-around and keep the first requester.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        w_sum   = 0;
        w_k     = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = int'(ptr) + i;
            if (w_sum >= N) begin
                w_sum = w_sum - N;
            end
            w_k = CH_W'(w_sum);
            if (en && !any && req[w_k]) begin
                gnt[w_k] = 1'b1;
                gnt_idx  = w_k;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clarke_sched.sv
// Round-robin scheduler sharing one Clarke unit among N_CH channels.
// Completion is timed by LAT; the Clarke done flag is not used.
module clarke_sched
    import clarke_pkg::*;
#(
    parameter int D_WIDTH = CLARKE_D_WIDTH,
    parameter int Q_BITS  = CLARKE_Q_BITS,
    parameter int N_CH    = 4,
    parameter int LAT     = 1,
    parameter int CH_W    = $clog2(N_CH)
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic [N_CH-1:0]           req_valid,
    output logic [N_CH-1:0]           req_ready,
    input  logic [N_CH*D_WIDTH-1:0]   req_a,
    input  logic [N_CH*D_WIDTH-1:0]   req_b,
    output logic                      cl_start,
    output logic [D_WIDTH-1:0]        cl_a,
    output logic [D_WIDTH-1:0]        cl_b,
    input  logic [D_WIDTH-1:0]        cl_alpha,
    input  logic [D_WIDTH-1:0]        cl_beta,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CH_W-1:0]           out_ch,
    output logic [D_WIDTH-1:0]        out_alpha,
    output logic [D_WIDTH-1:0]        out_beta,
    output logic                      busy
);

    localparam int CNT_W = 3;

    if (N_CH < 2 || N_CH > 16 || LAT < 1 || LAT > 7 ||
        Q_BITS >= D_WIDTH) begin : g_param_chk
        $error("clarke_sched: parameter out of range");
    end

    clarke_sched_state_t r_state;
    clarke_sched_state_t w_next;

    logic [CH_W-1:0]    r_ptr;
    logic [CH_W-1:0]    r_ch;
    logic [D_WIDTH-1:0] r_a;
    logic [D_WIDTH-1:0] r_b;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_valid;
    logic [CH_W-1:0]    r_out_ch;
    logic [D_WIDTH-1:0] r_alpha;
    logic [D_WIDTH-1:0] r_beta;

    logic [N_CH-1:0]    w_gnt;
    logic [CH_W-1:0]    w_gnt_idx;
    logic               w_any;
    logic               w_arb_en;
    logic               w_cnt_last;

    // Arbitration only in IDLE and never while reset is held.
    assign w_arb_en   = rstb && (r_state == IDLE);
    assign w_cnt_last = (r_cnt == CNT_W'(1));

    rr_arbiter #(
        .N    (N_CH),
        .CH_W (CH_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (r_ptr),
        .en      (w_arb_en),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    // State register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake/strobe outputs.
    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        cl_start  = 1'b0;
        busy      = (r_state != IDLE);
        unique case (r_state)
            IDLE: begin
                req_ready = w_gnt;
                if (w_any) w_next = ISSUE;
            end
            ISSUE: begin
                cl_start = 1'b1;
                w_next   = WAIT;
            end
            WAIT: begin
                if (w_cnt_last) w_next = HOLD;
            end
            HOLD: begin
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Latch the granted channel's operands and index.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_a  <= '0;
            r_b  <= '0;
            r_ch <= '0;
        end else if (r_state == IDLE && w_any) begin
            r_a  <= req_a[w_gnt_idx*D_WIDTH +: D_WIDTH];
            r_b  <= req_b[w_gnt_idx*D_WIDTH +: D_WIDTH];
            r_ch <= w_gnt_idx;
        end
    end

    // Latency counter: loaded on issue, counts down while waiting.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_cnt <= CNT_W'(LAT);
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Result capture, hold, and pointer advance on accept.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_alpha     <= '0;
            r_beta      <= '0;
            r_ptr       <= '0;
        end else if (r_state == WAIT && w_cnt_last) begin
            r_out_valid <= 1'b1;
            r_out_ch    <= r_ch;
            r_alpha     <= cl_alpha;
            r_beta      <= cl_beta;
        end else if (r_state == HOLD && out_ready) begin
            r_out_valid <= 1'b0;
            r_ptr       <= (r_ch == CH_W'(N_CH - 1)) ? '0 : r_ch + 1'b1;
        end
    end

    assign cl_a      = r_a;
    assign cl_b      = r_b;
    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_alpha = r_alpha;
    assign out_beta  = r_beta;

endmodule
